// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment scan driver. It holds the segment bit
// positions inside seg_out, the active-high hex glyph table, and hex_to_seg(),
// which turns a 4-bit value into its g..a segment pattern.
// -----------------------------------------------------------------------------
package seg7_pkg;

  // Bit positions of each segment inside the 8-bit segment word.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high glyphs. Each entry is {g,f,e,d,c,b,a}. Entry 0 sits at the
  // right-hand end of the concatenation.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,  // F E d C b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F   // 7 6 5 4 3 2 1 0
  };

  // Returns the active-high g..a pattern for one nibble. Each bit is placed by
  // its named position, so the table packing and the pin order are tied
  // together in a single place.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] glyph;
    logic [6:0] seg;
    glyph = GLYPH_TABLE[nibble];
    seg = '0;
    seg[SEG_A] = glyph[0];
    seg[SEG_B] = glyph[1];
    seg[SEG_C] = glyph[2];
    seg[SEG_D] = glyph[3];
    seg[SEG_E] = glyph[4];
    seg[SEG_F] = glyph[5];
    seg[SEG_G] = glyph[6];
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Groups the data and display pins of the scan driver.
//   master : the datapath side. It drives clear/load/digits_in/dp_in/blink_en/
//            lz_blank and observes seg_out/an_out/frame_tick.
//   slave  : the driver itself.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    clear;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_en;
  logic                    lz_blank;
  logic [7:0]              seg_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_tick;

  modport master (
    output clear, load, digits_in, dp_in, blink_en, lz_blank,
    input  seg_out, an_out, frame_tick
  );

  modport slave (
    input  clear, load, digits_in, dp_in, blink_en, lz_blank,
    output seg_out, an_out, frame_tick
  );
endinterface

// File: rtl/seg7_scan_timer.sv
// -----------------------------------------------------------------------------
// seg7_scan_timer
// Scan timebase for the driver. It contains:
//   - the slot prescaler p, which counts 0..CLK_DIV-1,
//   - the digit index idx, which advances when a slot ends,
//   - frame_tick, a registered one-cycle pulse after idx wraps to 0,
//   - a frame counter that toggles blink_phase every BLINK_FRAMES frames.
// Ports:
//   clk50MHz, rst  clock and asynchronous active-high reset
//   slot_active    p >= GUARD; the anode may be on
//   idx            digit currently being scanned
//   frame_tick     one-cycle pulse after the scan wraps to digit 0
//   blink_phase    1 = blinking digits are dark
// -----------------------------------------------------------------------------
module seg7_scan_timer #(
  parameter  int NUM_DIGITS   = 4,
  parameter  int CLK_DIV      = 10000,
  parameter  int GUARD        = 50,
  parameter  int BLINK_FRAMES = 250,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk50MHz,
  input  logic             rst,
  output logic             slot_active,
  output logic [IDX_W-1:0] idx,
  output logic             frame_tick,
  output logic             blink_phase
);

  localparam int P_W  = $clog2(CLK_DIV);
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [P_W-1:0]   P_LAST   = P_W'(CLK_DIV - 1);
  localparam logic [P_W-1:0]   P_GUARD  = P_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_FRAMES - 1);

  logic [P_W-1:0]  p;
  logic [BC_W-1:0] blink_cnt;
  logic            slot_end;
  logic            frame_wrap;

  assign slot_end    = (p == P_LAST);
  assign frame_wrap  = slot_end && (idx == IDX_LAST);
  assign slot_active = (p >= P_GUARD);

  // NOTE: use non-blocking (<=) in clocked blocks. Every register then
  // samples values from before the edge, and the order of the statements
  // does not matter.
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      p           <= '0;
      idx         <= '0;
      frame_tick  <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;

      if (slot_end) begin
        p   <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        p <= p + 1'b1;
      end

      if (frame_wrap) begin
        if (blink_cnt == BC_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed 7-segment driver. It latches NUM_DIGITS nibbles together
// with their decimal points and blink enables. It then scans one digit per
// slot, blanking all anodes for the first GUARD cycles of each slot to stop
// ghosting. It also applies leading-zero suppression and per-digit blinking.
// All outputs are registered, so they lag the scan state by one cycle.
// Ports:
//   clk50MHz, rst  clock and asynchronous active-high reset
//   bus (slave)    clear/load/digits_in/dp_in/blink_en/lz_blank in,
//                  seg_out ([6:0]=g..a, [7]=dp) / an_out / frame_tick out
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 10000,
  parameter int GUARD        = 50,
  parameter int BLINK_FRAMES = 250,
  parameter int ACTIVE_LOW   = 1
) (
  input logic              clk50MHz,
  input logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic INVERT = (ACTIVE_LOW != 0);

  logic [NUM_DIGITS-1:0][3:0] digits_q;
  logic [NUM_DIGITS-1:0]      dp_q;
  logic [NUM_DIGITS-1:0]      blink_q;

  logic                  slot_active;
  logic [IDX_W-1:0]      idx;
  logic                  blink_phase;

  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;
  logic                  blank;
  logic [7:0]            seg_hi;
  logic [NUM_DIGITS-1:0] an_hi;

  seg7_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .CLK_DIV      (CLK_DIV),
    .GUARD        (GUARD),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk50MHz    (clk50MHz),
    .rst         (rst),
    .slot_active (slot_active),
    .idx         (idx),
    .frame_tick  (bus.frame_tick),
    .blink_phase (blink_phase)
  );

  // Digit latch. clear has priority over load. Neither touches the scan
  // timebase, so loading new data never disturbs the display rhythm.
  // NOTE: these few storage bits get a reset because the display must come
  // up dark and all-zero. Larger storage arrays would normally be left
  // without one.
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      dp_q     <= '0;
      blink_q  <= '0;
    end else if (bus.clear) begin
      digits_q <= '0;
      dp_q     <= '0;
      blink_q  <= '0;
    end else if (bus.load) begin
      digits_q <= bus.digits_in;
      dp_q     <= bus.dp_in;
      blink_q  <= bus.blink_en;
    end
  end

  // lead_zero[i] = digit i and every digit above it are zero. Digit 0 is
  // never suppressed, so its bit stays 0.
  // NOTE: always_comb gives every output a default before any branch. A path
  // that leaves an output unassigned would otherwise infer a latch.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run     = zero_run && (digits_q[i] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  // Decode for the current slot, in active-high polarity. lz_blank is used
  // live rather than latched.
  always_comb begin
    blank  = (bus.lz_blank && lead_zero[idx]) || (blink_phase && blink_q[idx]);
    seg_hi = '0;
    if (!blank) begin
      seg_hi[SEG_G:SEG_A] = hex_to_seg(digits_q[idx]);
      seg_hi[SEG_DP]      = dp_q[idx];
    end
    an_hi = '0;
    if (slot_active) begin
      an_hi[idx] = 1'b1;
    end
  end

  // Output register. Polarity is applied here, so reset drives the pins
  // straight to their OFF level.
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      bus.seg_out <= INVERT ? '1 : '0;
      bus.an_out  <= INVERT ? '1 : '0;
    end else begin
      bus.seg_out <= INVERT ? ~seg_hi : seg_hi;
      bus.an_out  <= INVERT ? ~an_hi  : an_hi;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, CLK_DIV=4, GUARD=1,
// BLINK_FRAMES=2 and ACTIVE_LOW=1. One frame is 16 cycles. Each frame_tick
// cycle still shows digit 3. The next cycle is digit 0's guard cycle, which
// is followed by three lit cycles, and so on for each digit.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int CD = 4;
  localparam int GD = 1;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .CLK_DIV      (CD),
    .GUARD        (GD),
    .BLINK_FRAMES (BF),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk50MHz (clk),
    .rst      (rst),
    .bus      (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Counts frame_tick pulses since reset. When frame_tick is seen high at a
  // negedge, that pulse is not counted yet, so it is wrap number tick_cnt+1.
  int tick_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= 0;
    else if (bus.frame_tick) tick_cnt <= tick_cnt + 1;
  end

  logic [7:0] cap_seg [N];
  logic [3:0] cap_an  [N];
  logic       cap_guard_ok;
  logic       cap_stable_ok;
  int         cap_frame_no;

  task automatic drive_idle();
    bus.clear     = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.dp_in     = '0;
    bus.blink_en  = '0;
    bus.lz_blank  = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl, input logic lz, input logic clr);
    @(negedge clk);
    bus.digits_in = d;
    bus.dp_in     = dp;
    bus.blink_en  = bl;
    bus.lz_blank  = lz;
    bus.load      = 1'b1;
    bus.clear     = clr;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.clear = 1'b0;
  endtask

  // Returns at a negedge where frame_tick is high. A missing tick counts as
  // a failed comparison.
  task automatic wait_frame();
    int n;
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.frame_tick !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL frame_tick_timeout: got no frame_tick in 40 cycles, required one");
    end
  endtask

  // Captures one frame: a guard cycle, then three lit cycles per digit.
  task automatic capture_frame();
    wait_frame();
    cap_frame_no  = tick_cnt + 1;
    cap_guard_ok  = 1'b1;
    cap_stable_ok = 1'b1;
    for (int d = 0; d < N; d++) begin
      @(negedge clk);
      if (bus.an_out !== 4'hF) cap_guard_ok = 1'b0;
      @(negedge clk);
      cap_seg[d] = bus.seg_out;
      cap_an[d]  = bus.an_out;
      repeat (2) begin
        @(negedge clk);
        if (bus.seg_out !== cap_seg[d] || bus.an_out !== cap_an[d]) cap_stable_ok = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_seg [N];
    logic [3:0] exp_an  [N];
    exp_seg = '{e0, e1, e2, e3};
    exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    capture_frame();
    for (int d = 0; d < N; d++) begin
      tests_run++;
      if (cap_seg[d] !== exp_seg[d]) begin
        tests_failed++;
        $display("FAIL %s_seg[%0d]: got %h required %h", name, d, cap_seg[d], exp_seg[d]);
      end
      tests_run++;
      if (cap_an[d] !== exp_an[d]) begin
        tests_failed++;
        $display("FAIL %s_an[%0d]: got %h required %h", name, d, cap_an[d], exp_an[d]);
      end
    end
    tests_run++;
    if (cap_guard_ok !== 1'b1 || cap_stable_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_timing: guard_ok=%b stable_ok=%b required 1/1", name, cap_guard_ok, cap_stable_ok);
    end
  endtask

  // Checks the two cycles after reset is released, then the position of the
  // first frame_tick.
  task automatic check_restart(input string name);
    int n;
    @(negedge clk);
    tests_run++;
    if (bus.an_out !== 4'hF) begin
      tests_failed++;
      $display("FAIL %s_guard: an_out got %h required f", name, bus.an_out);
    end
    @(negedge clk);
    tests_run++;
    if (bus.an_out !== 4'hE || bus.seg_out !== 8'hC0) begin
      tests_failed++;
      $display("FAIL %s_first_digit: an/seg got %h/%h required e/c0", name, bus.an_out, bus.seg_out);
    end
    n = 2;
    while (bus.frame_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n != 16) begin
      tests_failed++;
      $display("FAIL %s_first_tick: got tick after %0d cycles required 16", name, n);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.seg_out !== 8'hFF || bus.an_out !== 4'hF || bus.frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: seg/an/tick got %h/%h/%b required ff/f/0",
               bus.seg_out, bus.an_out, bus.frame_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    check_restart("reset");
  endtask

  task automatic test_scan();
    do_load(16'h1250, 4'b0000, 4'b0000, 1'b0, 1'b0);
    check_frame("scan", 8'hC0, 8'h92, 8'hA4, 8'hF9);
  endtask

  task automatic test_frame_period();
    int n;
    wait_frame();
    @(negedge clk);
    n = 1;
    tests_run++;
    if (bus.frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL tick_width: frame_tick got %b one cycle later, required 0", bus.frame_tick);
    end
    while (bus.frame_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n != 16) begin
      tests_failed++;
      $display("FAIL tick_period: got %0d cycles required 16", n);
    end
  endtask

  task automatic test_leading_zero();
    // The dp bits of the suppressed digits must also stay dark.
    do_load(16'h0050, 4'b1100, 4'b0000, 1'b1, 1'b0);
    check_frame("lz_0050", 8'hC0, 8'h92, 8'hFF, 8'hFF);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    check_frame("lz_0000", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    // lz_blank is live: dropping it shows the zeros without a reload.
    @(negedge clk);
    bus.lz_blank = 1'b0;
    check_frame("lz_live", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
  endtask

  task automatic test_dp_hex();
    do_load(16'hBEEF, 4'b0100, 4'b0000, 1'b0, 1'b0);
    check_frame("dp_hex", 8'h8E, 8'h86, 8'h06, 8'h83);
  endtask

  task automatic test_blink();
    int on_cnt;
    int off_cnt;
    logic [7:0] exp0;
    on_cnt  = 0;
    off_cnt = 0;
    do_load(16'h000A, 4'b0000, 4'b0001, 1'b0, 1'b0);
    for (int f = 0; f < 4; f++) begin
      capture_frame();
      // The blink phase after wrap w is (w / BLINK_FRAMES) % 2.
      exp0 = (((cap_frame_no / BF) % 2) == 1) ? 8'hFF : 8'h88;
      if (cap_seg[0] == 8'h88) on_cnt++;
      if (cap_seg[0] == 8'hFF) off_cnt++;
      tests_run++;
      if (cap_seg[0] !== exp0 || cap_an[0] !== 4'hE) begin
        tests_failed++;
        $display("FAIL blink_d0 frame %0d: seg/an got %h/%h required %h/e",
                 cap_frame_no, cap_seg[0], cap_an[0], exp0);
      end
      tests_run++;
      if (cap_seg[1] !== 8'hC0 || cap_seg[2] !== 8'hC0 || cap_seg[3] !== 8'hC0) begin
        tests_failed++;
        $display("FAIL blink_others frame %0d: got %h %h %h required c0 c0 c0",
                 cap_frame_no, cap_seg[1], cap_seg[2], cap_seg[3]);
      end
    end
    tests_run++;
    if (on_cnt != 2 || off_cnt != 2) begin
      tests_failed++;
      $display("FAIL blink_duty: on/off frames got %0d/%0d required 2/2", on_cnt, off_cnt);
    end
  endtask

  task automatic test_clear_vs_load();
    int n;
    wait_frame();
    repeat (5) @(negedge clk);
    bus.digits_in = 16'hFFFF;
    bus.dp_in     = 4'hF;
    bus.blink_en  = 4'hF;
    bus.lz_blank  = 1'b0;
    bus.load      = 1'b1;
    bus.clear     = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.clear = 1'b0;
    n = 6;
    while (bus.frame_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n != 16) begin
      tests_failed++;
      $display("FAIL clear_phase: next tick after %0d cycles required 16", n);
    end
    check_frame("clear_a", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    check_frame("clear_b", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
  endtask

  task automatic test_midscan_reset();
    int n;
    do_load(16'h1250, 4'b0000, 4'b0000, 1'b0, 1'b0);
    n = 0;
    while (bus.an_out === 4'hF && n < 8) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (bus.an_out === 4'hF) begin
      tests_failed++;
      $display("FAIL midscan_pre: an_out got f required a lit digit");
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.seg_out !== 8'hFF || bus.an_out !== 4'hF || bus.frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL midscan_off: seg/an/tick got %h/%h/%b required ff/f/0",
               bus.seg_out, bus.an_out, bus.frame_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    check_restart("midscan");
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_scan();
    test_frame_period();
    test_leading_zero();
    test_dp_hex();
    test_blink();
    test_clear_vs_load();
    test_midscan_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got no end by 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised time-multiplexed 7-segment display driver for the board LED digits. Latches NUM_DIGITS 4-bit values on a load strobe and decodes them to hex glyphs internally. Scans one digit at a time with anti-ghost guard blanking, leading-zero suppression and per-digit blinking. It sits after the ALU/datapath result registers and the digit selection logic, and drives the anode and segment pins directly.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
CLK_DIV, 10000, clk50MHz cycles per digit slot (>= GUARD+2); 10000 gives a 5 kHz slot rate
GUARD, 50, cycles at the start of each slot with all anodes off
BLINK_FRAMES, 250, full scan frames per blink half-period (>= 1)
ACTIVE_LOW, 1, 1 = segment and anode outputs active-low; 0 = active-high

Ports:
clk50MHz  in  1  system clock
rst  in  1  asynchronous active-high reset
clear  in  1  synchronous clear of latched digits and dp
load  in  1  latch digits_in, dp_in, blink_en this cycle
digits_in  in  4*NUM_DIGITS  nibble i = digit i; digit 0 = least significant / rightmost
dp_in  in  NUM_DIGITS  decimal point per digit
blink_en  in  NUM_DIGITS  per-digit blink enable
lz_blank  in  1  leading-zero suppression enable (live, not latched)
seg_out  out  8  [6:0] = segments g..a, [7] = dp
an_out  out  NUM_DIGITS  one-hot anode enable
frame_tick  out  1  one-cycle pulse when the scan wraps from the last digit back to digit 0

Behaviour:
- Reset (async): prescaler p=0, digit index idx=0, blink counter=0, blink_phase=0, latched regs=0. Outputs are all OFF: seg_out=8'hFF and an_out all 1s when ACTIVE_LOW=1; all 0s otherwise. frame_tick=0.
- Prescaler: p counts 0..CLK_DIV-1. When p==CLK_DIV-1: p<=0 and idx<=idx+1, wrapping NUM_DIGITS-1 -> 0.
- Frame: an idx wrap sets frame_tick high for the next cycle. A blink counter counts frames 0..BLINK_FRAMES-1. On its wrap, blink_phase toggles.
- Latch: load=1 captures all three inputs at the clock edge. clear=1 zeroes latched digits, dp and blink_en. clear beats load in the same cycle. Neither clear nor load disturbs p, idx or blink state.
- Decode: 0-9 use standard glyphs. 10-15 show A,b,C,d,E,F.
- Active-high glyphs (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero suppression (lz_blank=1): digit i>0 is blanked (segments and dp off) if it and every more-significant digit are 0. Digit 0 is never suppressed.
- Blink: when blink_phase=1 and latched blink_en[idx]=1, the segments and dp of that digit are off. The anode still follows the scan.
- Anodes: the anode for idx is enabled only when p>=GUARD. All anodes are off while p<GUARD.
- Registered outputs: seg_out, an_out and frame_tick are registered. They reflect the state of (p, idx, latched regs) from the previous cycle, i.e. 1-cycle latency. No combinational path from inputs to outputs.
- ACTIVE_LOW=1 inverts all seg_out/an_out bits after decode. dp is on when the latched dp is 1 and the digit is not blanked.
- Reset mid-scan forces outputs OFF immediately (async). The scan restarts from idx=0, p=0.

Decomposition:
- Package seg7_pkg holds the 16-entry glyph constant table, the segment bit-index constants (SEG_A..SEG_G, SEG_DP) and the function hex_to_seg(nibble) returning 7 active-high bits.
- One sub-module, seg7_scan_timer, contains the prescaler, idx, frame_tick and blink counter/phase. It exports p>=GUARD as slot_active, plus idx and blink_phase.

Test Plan:
- Bench params NUM_DIGITS=4, CLK_DIV=4, GUARD=1, BLINK_FRAMES=2, ACTIVE_LOW=1.
- Reset: assert rst mid-slot -> seg_out=8'hFF and an_out=4'hF in the same cycle. After release, an_out=4'hE first appears on the cycle after p reaches 1.
- Scan/decode: load digits_in=16'h1250, dp_in=0, lz_blank=0 -> per slot, seg_out/an_out = C0/E, 92/D, A4/B, F9/7. an_out=F during each guard cycle. frame_tick pulses once every 16 cycles.
- Leading zero: load 16'h0050, lz_blank=1 -> digits 3 and 2 show seg_out=8'hFF and digit 0 shows C0. Load 16'h0000 -> only digit 0 lit, showing C0.
- Blink: load blink_en=4'b0001, digits 16'h000A, lz_blank=0 -> digit 0 shows 88 for 2 frames, then FF for 2 frames, alternating. Other digits are unaffected.
- Clear vs load: assert clear and load together with digits 16'hFFFF -> all digits show C0 (zero). Scan timing shows no phase disturbance and frame_tick stays periodic.
- dp/hex: load 16'hBEEF, dp_in=4'b0100 -> digit 2 shows 8'h06 (E with dp on). Digit 0 shows 8'h8E.
